xor_lrc_stream: RTL and testbench
=================================

Name: xor_lrc_stream

Overview:
- Parametrised, streaming successor to the team's 1-bit XOR gate: WIDTH-bit bitwise XOR of two operand words per beat.
- Input side uses a valid/ready handshake; output is a registered stage with backpressure.
- Keeps a running per-frame longitudinal XOR checksum (LRC) and reports it, with frame length and an overrun flag, at end of frame.
- Sits between a framed word source and a checksum/compare consumer.

Parameters:
WIDTH, 8, operand/result/LRC width in bits (>=1)
FRAME_MAX, 16, max beats per frame before overrun is flagged (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  a/b/in_last valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
in_last  input  1  beat is last of frame
out_valid  output  1  y/out_last valid
out_ready  input  1  consumer accepts output
y  output  WIDTH  registered a^b
out_last  output  1  registered in_last
lrc_valid  output  1  one-cycle pulse: lrc/frame_len/frame_err valid
lrc  output  WIDTH  XOR of all y in completed frame
frame_len  output  CW  beats in completed frame, saturating at FRAME_MAX; CW=$clog2(FRAME_MAX+1)
frame_err  output  1  completed frame exceeded FRAME_MAX beats (valid with lrc_valid)

Behaviour:
- Reset (async, any time): all outputs 0; in_ready=1 is NOT held in reset, 0 while rst high, 1 first cycle after; accumulator, counter, FSM cleared to IDLE.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept: y<=a^b, out_last<=in_last, out_valid<=1 next cycle; latency 1 cycle. If out_valid && out_ready && !accept: out_valid<=0. y/out_last stable while out_valid && !out_ready.
- Accumulator acc (WIDTH): on accepted non-last beat acc<=acc^(a^b); on accepted last beat acc<=0.
- Counter cnt (CW): increments per accepted beat, saturates at FRAME_MAX; cleared on accepted last beat.
- End of frame (accepted in_last): next cycle lrc_valid=1 for exactly one cycle, lrc=acc^(a^b), frame_len=min(cnt+1,FRAME_MAX), frame_err=1 iff the frame contained more than FRAME_MAX beats. lrc/frame_len/frame_err hold until next end of frame; lrc_valid has no backpressure.
- Single-beat frame (in_last on first beat): lrc=a^b, frame_len=1.
- FSM: IDLE (no beat in frame) -> IN_FRAME on accepted non-last beat; IN_FRAME -> OVERRUN when accepted non-last beat makes beat count exceed FRAME_MAX... precisely: accepted beat number FRAME_MAX+1 without last; any state -> IDLE on accepted last beat. OVERRUN: beats still pass through and XOR into acc; frame_err reported at end.
- in_valid low: no state change; out side drains independently.
- Reset mid-frame: partial frame discarded, no lrc_valid; next frame starts clean.

Decomposition:
- Shared package xor_pkg: state enum (IDLE, IN_FRAME, OVERRUN), helper function for CW width.
- One natural sub-module: xor_out_reg (valid/ready output register holding y/out_last); checksum/FSM in top.

Test Plan:
- Reset: assert rst mid-run -> same cycle all outputs 0, in_ready=0; after deassert in_ready=1, out_valid=0.
- Single beat a=8'hFF,b=8'h0F,in_last=1, out_ready=1 -> next cycle y=8'hF0, out_last=1, lrc_valid pulse, lrc=8'hF0, frame_len=1, frame_err=0.
- 3-beat frame (A5,5A),(0F,00),(F0,0F,last) back-to-back -> y=FF,0F,FF on consecutive cycles; lrc=8'h0F, frame_len=3.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after first beat, y held at first result, no beat lost; release -> remaining beats emerge in order.
- Overrun FRAME_MAX=4: 6 beats all (01,00) then last (01,00) -> lrc=8'h01 (7 beats odd), frame_len=4, frame_err=1; following 2-beat frame -> frame_err=0, frame_len=2.
- Reset mid-frame after 2 beats, then 1-beat frame (33,11,last) -> lrc=8'h22, frame_len=1, no lrc_valid from aborted frame.

Source files
------------

// File: rtl/xor_pkg.sv
// Shared definitions for the xor_lrc_stream block.
//   frame_state_t : frame tracking FSM states
//   cnt_width()   : width of a beat counter that must hold 0..frame_max
package xor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IN_FRAME,
        OVERRUN
    } frame_state_t;

    function automatic int cnt_width(input int frame_max);
        return $clog2(frame_max + 1);
    endfunction

endpackage

// File: rtl/xor_out_reg.sv
// Single-entry valid/ready output register holding the XOR result and its
// end-of-frame marker.
//   clk, rst             : clock, asynchronous active-high reset
//   load                 : capture next_y/next_last this cycle
//   next_y, next_last    : data to capture
//   out_ready            : downstream accepts the held word
//   out_valid, y,
//   out_last             : registered output word
module xor_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] next_y,
    input  logic             next_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             out_last
);

    // A load always wins over a drain so a word taken in the same cycle the
    // previous one leaves keeps out_valid high (full throughput).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            y         <= next_y;
            out_last  <= next_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/xor_lrc_stream.sv
// Streaming WIDTH-bit XOR with per-frame longitudinal XOR checksum (LRC).
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid/in_ready         : input handshake for a, b, in_last
//   out_valid/out_ready       : output handshake for y = a^b, out_last
//   lrc_valid                 : one-cycle pulse at end of frame
//   lrc, frame_len, frame_err : checksum, saturated beat count and overrun
//                               flag of the last completed frame
module xor_lrc_stream
    import xor_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int FRAME_MAX = 16,
    localparam int CW        = cnt_width(FRAME_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_last,
    output logic             lrc_valid,
    output logic [WIDTH-1:0] lrc,
    output logic [CW-1:0]    frame_len,
    output logic             frame_err
);

    frame_state_t     state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             cnt_full;
    logic [WIDTH-1:0] beat_xor;

    // in_ready is forced low while reset is asserted so nothing is accepted
    // into a block that is being cleared.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign beat_xor = a ^ b;
    assign cnt_full = (cnt == CW'(FRAME_MAX));

    xor_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .next_y   (beat_xor),
        .next_last(in_last),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .y        (y),
        .out_last (out_last)
    );

    // cnt holds the number of beats already accepted in the current frame
    // (saturated), so a last beat arriving with cnt already at FRAME_MAX is
    // beat FRAME_MAX+1 and the frame is an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            lrc_valid <= 1'b0;
            lrc       <= '0;
            frame_len <= '0;
            frame_err <= 1'b0;
        end else begin
            lrc_valid <= 1'b0;
            if (accept) begin
                if (in_last) begin
                    lrc_valid <= 1'b1;
                    lrc       <= acc ^ beat_xor;
                    frame_len <= cnt_full ? CW'(FRAME_MAX) : cnt + CW'(1);
                    frame_err <= (state == OVERRUN) || cnt_full;
                    acc       <= '0;
                    cnt       <= '0;
                    state     <= IDLE;
                end else begin
                    acc <= acc ^ beat_xor;
                    if (!cnt_full) begin
                        cnt <= cnt + CW'(1);
                    end
                    case (state)
                        IDLE:     state <= cnt_full ? OVERRUN : IN_FRAME;
                        IN_FRAME: if (cnt_full) state <= OVERRUN;
                        OVERRUN:  state <= OVERRUN;
                        default:  state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_lrc_stream.sv
// Directed self-checking bench for xor_lrc_stream (WIDTH=8, FRAME_MAX=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_xor_lrc_stream;

    localparam int WIDTH     = 8;
    localparam int FRAME_MAX = 4;
    localparam int CW        = $clog2(FRAME_MAX + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             out_last;
    logic             lrc_valid;
    logic [WIDTH-1:0] lrc;
    logic [CW-1:0]    frame_len;
    logic             frame_err;

    int checks;
    int fails;

    xor_lrc_stream #(
        .WIDTH    (WIDTH),
        .FRAME_MAX(FRAME_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .out_last (out_last),
        .lrc_valid(lrc_valid),
        .lrc      (lrc),
        .frame_len(frame_len),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] va, input logic [7:0] vb,
                         input logic last);
        in_valid = v;
        a        = va;
        b        = vb;
        in_last  = last;
    endtask

    task automatic test_reset;
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h26) begin
            fails++;
            $display("[TB] FAIL pre_reset_beat: out_valid=%b y=%h, expected 1/26", out_valid, y);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, y, out_last, lrc_valid, lrc, frame_len, frame_err, in_ready} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: ov=%b y=%h ol=%b lv=%b lrc=%h len=%0d err=%b ir=%b, expected all 0",
                     out_valid, y, out_last, lrc_valid, lrc, frame_len, frame_err, in_ready);
        end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL after_reset: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_beat;
        drive(1'b1, 8'hFF, 8'h0F, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || y !== 8'hF0 || out_last !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_y: ov=%b y=%h last=%b, expected 1/f0/1", out_valid, y, out_last);
        end
        checks++;
        if (lrc_valid !== 1'b1 || lrc !== 8'hF0 || frame_len !== CW'(1) || frame_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_lrc: lv=%b lrc=%h len=%0d err=%b, expected 1/f0/1/0",
                     lrc_valid, lrc, frame_len, frame_err);
        end
        @(negedge clk);
        checks++;
        if (lrc_valid !== 1'b0 || out_valid !== 1'b0 || lrc !== 8'hF0) begin
            fails++;
            $display("[TB] FAIL single_pulse: lv=%b ov=%b lrc=%h, expected 0/0/f0", lrc_valid, out_valid, lrc);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        drive(1'b1, 8'hA5, 8'h5A, 1'b0);
        @(negedge clk);
        checks++;
        if (y !== 8'hFF || out_valid !== 1'b1 || out_last !== 1'b0 || lrc_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_beat1: y=%h ov=%b ol=%b lv=%b, expected ff/1/0/0", y, out_valid, out_last, lrc_valid);
        end
        drive(1'b1, 8'h0F, 8'h00, 1'b0);
        @(negedge clk);
        checks++;
        if (y !== 8'h0F || out_valid !== 1'b1 || lrc_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_beat2: y=%h ov=%b lv=%b, expected 0f/1/0", y, out_valid, lrc_valid);
        end
        drive(1'b1, 8'hF0, 8'h0F, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (y !== 8'hFF || out_last !== 1'b1 || lrc_valid !== 1'b1 || lrc !== 8'h0F ||
            frame_len !== CW'(3) || frame_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_end: y=%h ol=%b lv=%b lrc=%h len=%0d err=%b, expected ff/1/1/0f/3/0",
                     y, out_last, lrc_valid, lrc, frame_len, frame_err);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'h33, 8'h44, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 8'h33) begin
                fails++;
                $display("[TB] FAIL bp_hold%0d: ir=%b ov=%b y=%h, expected 0/1/33", i, in_ready, out_valid, y);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bp_release: in_ready=%b, expected 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (y !== 8'h77 || out_valid !== 1'b1 || out_last !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_beat2: y=%h ov=%b ol=%b, expected 77/1/0", y, out_valid, out_last);
        end
        drive(1'b1, 8'h55, 8'h66, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (y !== 8'h33 || out_last !== 1'b1 || lrc_valid !== 1'b1 || lrc !== 8'h77 || frame_len !== CW'(3)) begin
            fails++;
            $display("[TB] FAIL bp_end: y=%h ol=%b lv=%b lrc=%h len=%0d, expected 33/1/1/77/3",
                     y, out_last, lrc_valid, lrc, frame_len);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_drain: out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_overrun;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h01, 8'h00, 1'b0);
            @(negedge clk);
            checks++;
            if (lrc_valid !== 1'b0 || y !== 8'h01) begin
                fails++;
                $display("[TB] FAIL ovr_beat%0d: lv=%b y=%h, expected 0/01", i, lrc_valid, y);
            end
        end
        drive(1'b1, 8'h01, 8'h00, 1'b1);
        @(negedge clk);
        checks++;
        if (lrc_valid !== 1'b1 || lrc !== 8'h01 || frame_len !== CW'(4) || frame_err !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ovr_end: lv=%b lrc=%h len=%0d err=%b, expected 1/01/4/1",
                     lrc_valid, lrc, frame_len, frame_err);
        end
        drive(1'b1, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'h56, 8'h78, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (lrc_valid !== 1'b1 || lrc !== 8'h08 || frame_len !== CW'(2) || frame_err !== 1'b0 || y !== 8'h2E) begin
            fails++;
            $display("[TB] FAIL ovr_next: lv=%b lrc=%h len=%0d err=%b y=%h, expected 1/08/2/0/2e",
                     lrc_valid, lrc, frame_len, frame_err, y);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        out_ready = 1'b1;
        drive(1'b1, 8'hAA, 8'h00, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'hBB, 8'h00, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (lrc_valid !== 1'b0 || lrc !== 8'h00 || out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_cleared: lv=%b lrc=%h ov=%b, expected 0/00/0", lrc_valid, lrc, out_valid);
        end
        drive(1'b1, 8'h33, 8'h11, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (lrc_valid !== 1'b1 || lrc !== 8'h22 || frame_len !== CW'(1) || frame_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_next: lv=%b lrc=%h len=%0d err=%b, expected 1/22/1/0",
                     lrc_valid, lrc, frame_len, frame_err);
        end
        @(negedge clk);
        checks++;
        if (lrc_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_pulse: lv=%b, expected 0", lrc_valid);
        end
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
